nibble_serializer: RTL and testbench

- Upstream feeder for the 4-bit serial-in shift register. Accepts parallel words over a valid/ready handshake and buffers them in a small holding FIFO.
- Drives each word MSB-first, one bit per clock, onto the shift register's serial D input.
- Pulses frame_done on the cycle the downstream register holds a complete, aligned word (O3 = first bit sent, O0 = last).

---
 rtl/nibble_serializer.sv | 120 ++++++++++++
 tb/tb_nibble_serializer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serializer.sv
// nibble_serializer: buffers parallel words in a small FIFO and drives each
// word MSB-first, one bit per clock, onto a downstream serial-in shift
// register. frame_done pulses when the downstream register holds a full word.
module nibble_serializer #(
  parameter int   WIDTH      = 4,
  parameter int   FIFO_DEPTH = 2,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          ser_out,
  output logic                          frame_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    frame_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [BW-1:0] LAST_BIT = WIDTH[BW-1:0];
  localparam logic [BW-1:0] ONE_BIT  = 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [WIDTH-1:0]  shreg;
  logic [BW-1:0]     bitcnt;
  logic [WIDTH-1:0]  head;
  logic              push;
  logic              pop;
  logic              frame_end;

  assign in_ready  = (fifo_count < FULL_CNT);
  assign push      = in_valid & in_ready;
  assign frame_end = (state == SHIFT) && (bitcnt == LAST_BIT);
  // A word is taken either to start from idle or to chain straight after the
  // last bit of the current frame, so frames stream with no gap bit.
  assign pop       = (fifo_count != '0) && ((state == IDLE) || frame_end);
  assign head      = mem[rd_ptr];

  // FIFO storage write; contents need no reset since count gates reads
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Serializer FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ser_out    <= IDLE_BIT;
      shreg      <= '0;
      bitcnt     <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            ser_out <= head[WIDTH-1];
            shreg   <= {head[WIDTH-2:0], 1'b0};
            bitcnt  <= ONE_BIT;
            state   <= SHIFT;
            busy    <= 1'b1;
          end else begin
            ser_out <= IDLE_BIT;
          end
        end
        SHIFT: begin
          if (bitcnt != LAST_BIT) begin
            ser_out <= shreg[WIDTH-1];
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bitcnt  <= bitcnt + ONE_BIT;
          end else begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
            if (pop) begin
              ser_out <= head[WIDTH-1];
              shreg   <= {head[WIDTH-2:0], 1'b0};
              bitcnt  <= ONE_BIT;
            end else begin
              ser_out <= IDLE_BIT;
              shreg   <= '0;
              bitcnt  <= '0;
              state   <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// Testbench for nibble_serializer: transaction-level reference model plus a
// downstream 4-bit shift register, compared against the DUT every cycle.
module tb_nibble_serializer;

  localparam int   WIDTH    = 4;
  localparam int   DEPTH    = 2;
  localparam logic IDLE_BIT = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       ser_out;
  logic       frame_done;
  logic       busy;
  logic [1:0] fifo_count;
  logic [7:0] frame_cnt;

  nibble_serializer #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .IDLE_BIT(IDLE_BIT)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_out(ser_out), .frame_done(frame_done),
    .busy(busy), .fifo_count(fifo_count), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [3:0] m_fifo[$];
  logic [3:0] acc_q[$];
  bit         m_active;
  int         m_sent;
  logic [3:0] m_word;
  logic       m_ser;
  logic       m_done;
  logic [7:0] m_cnt;

  logic [3:0] dsr;        // downstream shift register (O3..O0)
  logic       last_ser;
  logic       stream[$];  // bits seen while busy
  int         cycle = 0;
  int         done_pulses = 0;
  int         done_cycles[$];
  int         rx_count = 0;
  bit         saw_full = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_fifo.delete();
    acc_q.delete();
    m_active = 0;
    m_sent   = 0;
    m_word   = '0;
    m_ser    = IDLE_BIT;
    m_done   = 0;
    m_cnt    = '0;
    dsr      = '0;
    last_ser = IDLE_BIT;
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  function automatic void model_edge();
    bit take;
    if (!reset) begin
      model_reset();
      return;
    end
    take   = in_valid && (m_fifo.size() < DEPTH);
    m_done = m_active && (m_sent == WIDTH);
    if (m_done) m_cnt++;
    if (!m_active || m_sent == WIDTH) begin
      if (m_fifo.size() > 0) begin
        m_word   = m_fifo.pop_front();
        m_sent   = 1;
        m_active = 1;
      end else begin
        m_active = 0;
        m_sent   = 0;
      end
    end else begin
      m_sent++;
    end
    if (take) begin
      m_fifo.push_back(in_data);
      acc_q.push_back(in_data);
    end
    m_ser = m_active ? m_word[WIDTH - m_sent] : IDLE_BIT;
  endfunction

  task automatic compare();
    logic [3:0] w;
    chk("ser_out",    ser_out,    m_ser);
    chk("frame_done", frame_done, m_done);
    chk("busy",       busy,       m_active);
    chk("in_ready",   in_ready,   (m_fifo.size() < DEPTH));
    chk("fifo_count", fifo_count, m_fifo.size());
    chk("frame_cnt",  frame_cnt,  m_cnt);
    if (m_done) begin
      if (acc_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL downstream_word: frame completed with no word outstanding");
      end else begin
        w = acc_q.pop_front();
        chk("downstream_word", dsr, w);
        rx_count++;
      end
    end
    if (frame_done === 1'b1) begin
      done_pulses++;
      done_cycles.push_back(cycle);
    end
    if (fifo_count == 2'd2 && in_ready == 1'b0) saw_full = 1;
    if (busy === 1'b1) stream.push_back(ser_out);
    last_ser = ser_out;
  endtask

  task automatic step();
    @(posedge clk);
    dsr = {dsr[2:0], last_ser};
    model_edge();
    cycle++;
    @(negedge clk);
    compare();
  endtask

  task automatic push_word(input logic [3:0] w);
    bit acc;
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    do begin
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL push_timeout: word %0h not accepted, expected acceptance within 100 cycles", w);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy !== 1'b0 || fifo_count !== 2'd0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL %s_timeout: busy=%0b count=%0d, expected idle", name, busy, fifo_count);
    end
  endtask

  function automatic logic [31:0] stream_val();
    logic [31:0] v = '0;
    foreach (stream[i]) v = {v[30:0], stream[i]};
    return v;
  endfunction

  task automatic async_reset_check(input string name);
    reset = 1'b0;
    #1;
    chk({name, "_ser_out"},    ser_out,    1'b0);
    chk({name, "_busy"},       busy,       1'b0);
    chk({name, "_frame_done"}, frame_done, 1'b0);
    chk({name, "_fifo_count"}, fifo_count, 0);
    model_reset();
  endtask

  initial begin
    int p0, r0;
    logic [3:0] w;
    model_reset();

    // reset held with in_valid asserted: nothing accepted
    in_valid = 1'b1;
    in_data  = 4'hF;
    repeat (4) step();
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_frame_cnt", frame_cnt, 8'd0);
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (3) step();

    // single word 1011
    stream.delete();
    p0 = done_pulses;
    push_word(4'b1011);
    in_valid = 1'b0;
    wait_idle("single");
    step();
    chk("single_len", stream.size(), 4);
    chk("single_bits", stream_val(), 32'b1011);
    chk("single_pulses", done_pulses - p0, 1);
    chk("single_frame_cnt", frame_cnt, 8'd1);
    chk("single_idle_ser", ser_out, 1'b0);

    // back-to-back A,5,F with valid held high
    stream.delete();
    done_cycles.delete();
    saw_full = 0;
    push_word(4'hA);
    push_word(4'h5);
    push_word(4'hF);
    in_valid = 1'b0;
    wait_idle("b2b");
    step();
    chk("b2b_bits", stream_val(), 32'hA5F);
    chk("b2b_pulses", done_cycles.size(), 3);
    if (done_cycles.size() == 3) begin
      chk("b2b_gap0", done_cycles[1] - done_cycles[0], 4);
      chk("b2b_gap1", done_cycles[2] - done_cycles[1], 4);
    end
    chk("b2b_saw_full", saw_full, 1);
    chk("b2b_frame_cnt", frame_cnt, 8'd4);

    // randomized traffic with backpressure; source holds data while stalled
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 4'($urandom);
      end
      step();
    end
    in_valid = 1'b0;
    wait_idle("random");

    // asynchronous reset two bits into 1100
    push_word(4'b1100);
    in_valid = 1'b0;
    step();
    step();
    p0 = done_pulses;
    async_reset_check("midframe");
    in_valid = 1'b1;
    in_data  = 4'h9;
    repeat (3) step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    chk("midframe_no_done", done_pulses - p0, 0);
    chk("midframe_cnt", frame_cnt, 8'd0);
    stream.delete();
    push_word(4'b0110);
    in_valid = 1'b0;
    wait_idle("after_reset");
    step();
    chk("after_reset_bits", stream_val(), 32'b0110);
    chk("after_reset_len", stream.size(), 4);

    // 256 frames: counter wraps, pointers wrap, every word compared downstream
    async_reset_check("wrap");
    step();
    reset = 1'b1;
    step();
    r0 = rx_count;
    for (int i = 0; i < 256; i++) begin
      w = 4'($urandom);
      push_word(w);
    end
    in_valid = 1'b0;
    wait_idle("wrap");
    step();
    chk("wrap_frames", rx_count - r0, 256);
    chk("wrap_frame_cnt", frame_cnt, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
